uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
- Sequences the UART receiver (8N1, byte output with level-held valid and a timeout clear flag) to load a program image into instruction memory before the CPU starts.
- Packs received bytes into 32-bit words, writes them to consecutive addresses over a req/ack memory port, and holds the CPU off until the image is complete.
- Sits between the UART receiver and the instruction-memory write port. Drives the CPU hold line.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory.
- BASE_ADDR, 0, first word address written.
- MAX_WORDS, 256, capacity in words; must be ≤ 2^ADDR_WIDTH.

Ports:
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  reset, synchronous, active-high.
- i_rx_data  input  8  received byte from the UART receiver.
- i_rx_valid  input  1  byte valid, level; may stay high for many i_clk cycles.
- i_rx_clear  input  1  UART idle-timeout flag, level.
- i_mem_ack  input  1  memory accepted the current write.
- i_restart  input  1  one-cycle pulse; re-arms the loader from DONE.
- o_mem_req  output  1  write request.
- o_mem_addr  output  ADDR_WIDTH  word address.
- o_mem_wdata  output  32  write data.
- o_cpu_hold  output  1  1 = CPU held in reset/stall.
- o_done  output  1  image loaded.
- o_overflow  output  1  sticky: a byte was dropped.
- o_word_count  output  ADDR_WIDTH+1  number of words written.

Behaviour:
- Reset values:
  - o_mem_req=0, o_mem_addr=BASE_ADDR, o_mem_wdata=0.
  - o_cpu_hold=1, o_done=0, o_overflow=0, o_word_count=0.
  - Internal byte counter=0, skid register empty, edge registers=0.
- Reset mid-operation aborts any request; o_mem_req falls in the next cycle.
- Edge detect:
  - byte_strobe = i_rx_valid & ~valid_q.
  - clear_rise = i_rx_clear & ~clear_q.
  - One byte is consumed per strobe, never per valid-high cycle.
- Byte order: big-endian. The first byte of a word lands in wdata[31:24]. Shift rule: word <= {word[23:0], byte}.
- States: IDLE, RECV, WRITE, FLUSH, DONE.
- IDLE:
  - clear_rise is ignored (no image yet).
  - byte_strobe: shift the byte in, byte_cnt=1, go to RECV.
- RECV:
  - byte_strobe: shift the byte in, byte_cnt+1.
  - If that byte makes byte_cnt reach 4: byte_cnt=0, go to WRITE.
  - clear_rise with byte_cnt>0: go to FLUSH.
  - clear_rise with byte_cnt=0: go to DONE.
  - strobe and clear_rise in the same cycle: the byte is included first, then the clear is evaluated against the updated count.
- FLUSH:
  - Zero-pad the low bytes. Shift left by 8×(4−byte_cnt).
  - Takes one cycle, then WRITE. After that write completes, go to DONE.
- WRITE:
  - o_mem_req=1 in the cycle after entry.
  - o_mem_addr and o_mem_wdata are held stable until the cycle i_mem_ack=1.
  - On ack: o_mem_req=0, o_mem_addr+1, o_word_count+1. Go to RECV, or to DONE if entered from FLUSH.
  - o_mem_addr wraps modulo 2^ADDR_WIDTH (reachable only if MAX_WORDS=2^ADDR_WIDTH; it is never used afterwards).
  - A byte_strobe during WRITE or FLUSH goes into the one-byte skid register and is applied in the first RECV cycle.
  - A second strobe while the skid register is full is dropped and sets o_overflow.
  - clear_rise during WRITE is latched and acted on once back in RECV.
- Capacity:
  - When o_word_count == MAX_WORDS, further bytes are dropped and set o_overflow.
  - No further writes occur. The timeout still leads to DONE.
- DONE:
  - o_done=1, o_cpu_hold=0. Bytes are ignored.
  - i_restart: clears the count, address, overflow and word register; sets o_cpu_hold=1, o_done=0; goes to IDLE.
  - i_restart outside DONE is ignored.
- Latency: from the 4th byte strobe to o_mem_req high is 2 cycles (strobe register, then WRITE entry).

Decomposition:
- Shared package boot_pkg:
  - state encoding constants (IDLE..DONE, 3 bits);
  - WORD_BYTES=4;
  - the byte-order select constant.
- One natural sub-module, uart_byte_packer: edge detect, skid register, shift register and byte_cnt, with pad/flush input.
- The FSM, address and count logic live in the top module.

Test Plan:
- 8 bytes 01..08 sent, ack after 1 cycle, then timeout → writes 0x01020304 @0 and 0x05060708 @1; o_word_count=2; o_done=1; o_cpu_hold=0.
- 6 bytes AA BB CC DD EE FF, then timeout → writes 0xAABBCCDD @0 and 0xEEFF0000 @1; o_done=1; o_overflow=0.
- i_rx_valid held high 500 cycles per byte → each byte counted once; 4 bytes give exactly one write.
- Ack delayed 20 cycles, one byte arrives during WRITE → req/addr/data stable throughout; the skid byte becomes the first byte of the next word; o_overflow=0. Two bytes during WRITE → o_overflow=1.
- MAX_WORDS=2 with 12 bytes sent → only 2 writes; o_overflow=1; DONE after timeout. Timeout in IDLE → stays IDLE with hold=1.
- i_rst asserted while o_mem_req=1 → next cycle all outputs at reset values. i_restart in DONE → hold=1, count=0, IDLE; a reload to addr 0 succeeds.

Source files
------------

// File: rtl/uart_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types, constants and byte-packing helpers for the
//                UART boot loader.
//  Revision    : 1.0  initial release
// ============================================================================
package boot_pkg;

  // Bytes packed into one instruction-memory word.
  localparam int WORD_BYTES = 4;

  // Byte-order select: 1 = big-endian (first byte lands in bits [31:24]).
  localparam bit BYTE_ORDER_BIG = 1'b1;

  // Loader FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } boot_state_e;

  // Insert one byte into the word being assembled.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  data);
    if (BYTE_ORDER_BIG) return {word[23:0], data};
    return {data, word[31:8]};
  endfunction

  // Move a partial word (cnt bytes, 1..3) into final position, zero-filling
  // the byte lanes that were never received.
  function automatic logic [31:0] pad_word(input logic [31:0] word,
                                           input logic [2:0]  cnt);
    logic [5:0] sh;
    sh = {3'(3'(WORD_BYTES) - cnt), 3'b000};
    if (BYTE_ORDER_BIG) return word << sh;
    return word >> sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_boot_loader_packer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_packer
//  Description : Edge detection of the UART valid/clear levels, one-byte skid
//                register, word shift register and byte counter. All policy
//                (when to take, park or drop a byte) comes from the parent.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_clear,
  input  logic        i_take,       // shift a byte into the word this cycle
  input  logic        i_take_skid,  // byte source is the skid register
  input  logic        i_skid_load,  // park the incoming byte in the skid
  input  logic        i_skid_drop,  // discard the skid contents
  input  logic        i_flush,      // zero-pad the partial word
  input  logic        i_clear,      // wipe word, count and skid
  output logic        o_byte_strobe,
  output logic        o_clear_rise,
  output logic        o_skid_full,
  output logic [31:0] o_word,
  output logic [2:0]  o_cnt_after,  // byte count including this cycle's take
  output logic        o_word_full   // this cycle's take completes a word
);

  import boot_pkg::*;

  logic        valid_q, valid_d;
  logic        clear_q, clear_d;
  logic        skid_full_q, skid_full_d;
  logic [7:0]  skid_byte_q, skid_byte_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  byte_in;

  assign o_byte_strobe = i_rx_valid & ~valid_q;
  assign o_clear_rise  = i_rx_clear & ~clear_q;
  assign o_skid_full   = skid_full_q;
  assign o_word        = word_q;
  assign byte_in       = i_take_skid ? skid_byte_q : i_rx_data;
  assign o_cnt_after   = i_take ? cnt_q + 3'd1 : cnt_q;
  assign o_word_full   = (o_cnt_after == 3'(WORD_BYTES));

  // Next-state for edge, skid, shift and count registers.
  always_comb begin
    valid_d     = i_rx_valid;
    clear_d     = i_rx_clear;
    skid_full_d = skid_full_q;
    skid_byte_d = skid_byte_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    if (i_take) begin
      word_d = shift_in_byte(word_q, byte_in);
      cnt_d  = o_word_full ? 3'd0 : o_cnt_after;
    end
    // Draining and refilling the skid in one cycle leaves it full.
    if (i_take_skid || i_skid_drop) skid_full_d = 1'b0;
    if (i_skid_load) begin
      skid_full_d = 1'b1;
      skid_byte_d = i_rx_data;
    end
    if (i_flush) begin
      word_d = pad_word(word_q, cnt_q);
      cnt_d  = 3'd0;
    end
    if (i_clear) begin
      word_d      = 32'd0;
      cnt_d       = 3'd0;
      skid_full_d = 1'b0;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
      skid_full_q <= 1'b0;
      skid_byte_q <= 8'd0;
      word_q      <= 32'd0;
      cnt_q       <= 3'd0;
    end else begin
      valid_q     <= valid_d;
      clear_q     <= clear_d;
      skid_full_q <= skid_full_d;
      skid_byte_q <= skid_byte_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_boot_loader
//  Description : Loads a program image received over UART into instruction
//                memory as big-endian 32-bit words, holding the CPU off until
//                the idle timeout marks the end of the image.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_rx_clear,
  input  logic                  i_mem_ack,
  input  logic                  i_restart,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  import boot_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] c_base_addr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_max_words = (ADDR_WIDTH+1)'(MAX_WORDS);
  localparam logic [ADDR_WIDTH:0]   c_count_one = (ADDR_WIDTH+1)'(1);

  boot_state_e           state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  from_flush_q, from_flush_d;   // current write is the padded tail
  logic                  clear_pend_q, clear_pend_d;   // timeout seen while writing

  logic        take, take_skid, skid_load, skid_drop, flush, pk_clear;
  logic        byte_strobe, clear_rise, skid_full, word_full;
  logic [31:0] word;
  logic [2:0]  cnt_after;
  logic        cap_full, clear_evt;

  uart_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .i_rx_clear   (i_rx_clear),
    .i_take       (take),
    .i_take_skid  (take_skid),
    .i_skid_load  (skid_load),
    .i_skid_drop  (skid_drop),
    .i_flush      (flush),
    .i_clear      (pk_clear),
    .o_byte_strobe(byte_strobe),
    .o_clear_rise (clear_rise),
    .o_skid_full  (skid_full),
    .o_word       (word),
    .o_cnt_after  (cnt_after),
    .o_word_full  (word_full)
  );

  assign cap_full  = (word_count_q == c_max_words);
  assign clear_evt = clear_rise | clear_pend_q;

  // Loader FSM: byte routing, write handshake, address and count tracking.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    from_flush_d = from_flush_q;
    clear_pend_d = clear_pend_q;
    take         = 1'b0;
    take_skid    = 1'b0;
    skid_load    = 1'b0;
    skid_drop    = 1'b0;
    flush        = 1'b0;
    pk_clear     = 1'b0;

    // While a word is in flight, one byte may be parked; a second is lost.
    if ((state_q == ST_WRITE || state_q == ST_FLUSH) && byte_strobe) begin
      if (!skid_full) skid_load  = 1'b1;
      else            overflow_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        clear_pend_d = 1'b0;
        if (byte_strobe) begin
          take    = 1'b1;
          state_d = ST_RECV;
        end
      end

      ST_RECV: begin
        if (cap_full) begin
          if (skid_full) begin
            skid_drop  = 1'b1;
            overflow_d = 1'b1;
          end
          if (byte_strobe) overflow_d = 1'b1;
        end else if (skid_full) begin
          // Parked byte goes first; a fresh byte refills the skid.
          take      = 1'b1;
          take_skid = 1'b1;
          if (byte_strobe) skid_load = 1'b1;
        end else if (byte_strobe) begin
          take = 1'b1;
        end
        // The timeout is judged against the count after this cycle's byte.
        if (word_full) begin
          state_d      = ST_WRITE;
          from_flush_d = 1'b0;
          if (clear_evt) clear_pend_d = 1'b1;
        end else if (clear_evt) begin
          clear_pend_d = 1'b0;
          state_d      = (cnt_after != 3'd0) ? ST_FLUSH : ST_DONE;
        end
      end

      ST_FLUSH: begin
        flush        = 1'b1;
        clear_pend_d = 1'b0;
        from_flush_d = 1'b1;
        state_d      = ST_WRITE;
      end

      ST_WRITE: begin
        if (clear_rise) clear_pend_d = 1'b1;
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_wdata_d = word;
        end else if (i_mem_ack) begin
          mem_req_d    = 1'b0;
          mem_addr_d   = mem_addr_q + c_addr_one;
          word_count_d = word_count_q + c_count_one;
          state_d      = from_flush_q ? ST_DONE : ST_RECV;
        end
      end

      ST_DONE: begin
        if (i_restart) begin
          state_d      = ST_IDLE;
          mem_addr_d   = c_base_addr;
          mem_wdata_d  = 32'd0;
          overflow_d   = 1'b0;
          word_count_d = '0;
          from_flush_d = 1'b0;
          clear_pend_d = 1'b0;
          pk_clear     = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    done_d     = (state_d == ST_DONE);
    cpu_hold_d = ~done_d;
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= c_base_addr;
      mem_wdata_q  <= 32'd0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
      from_flush_q <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
      from_flush_q <= from_flush_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_cpu_hold   = cpu_hold_q;
  assign o_done       = done_q;
  assign o_overflow   = overflow_q;
  assign o_word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_boot_loader
//  Description : Scoreboard bench for uart_boot_loader. Expected writes are
//                queued by the stimulus; monitors pop them on each handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_boot_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, restart;
  logic [7:0]  rx_data, cap_rx_data;
  logic        rx_valid, rx_clear, mem_ack, cap_rx_valid, cap_rx_clear, cap_mem_ack;
  logic        mem_req, cpu_hold, done, overflow;
  logic        cap_mem_req, cap_cpu_hold, cap_done, cap_overflow;
  logic [7:0]  mem_addr, cap_mem_addr;
  logic [31:0] mem_wdata, cap_mem_wdata;
  logic [8:0]  word_count, cap_word_count;

  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 1;
  wr_t exp_q[$];
  wr_t cap_exp_q[$];

  uart_boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_rx_clear(rx_clear), .i_mem_ack(mem_ack), .i_restart(restart),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_cpu_hold(cpu_hold), .o_done(done), .o_overflow(overflow),
    .o_word_count(word_count)
  );

  uart_boot_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0), .MAX_WORDS(2)) dut_cap (
    .i_clk(clk), .i_rst(rst), .i_rx_data(cap_rx_data), .i_rx_valid(cap_rx_valid),
    .i_rx_clear(cap_rx_clear), .i_mem_ack(cap_mem_ack), .i_restart(1'b0),
    .o_mem_req(cap_mem_req), .o_mem_addr(cap_mem_addr), .o_mem_wdata(cap_mem_wdata),
    .o_cpu_hold(cap_cpu_hold), .o_done(cap_done), .o_overflow(cap_overflow),
    .o_word_count(cap_word_count)
  );

  // Memory responders: ack after ack_delay cycles of request, one cycle wide.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req) begin
        cnt++;
        if (cnt >= ack_delay) begin mem_ack = 1'b1; cnt = 0; end
      end else cnt = 0;
    end
  end

  initial begin
    cap_mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (cap_mem_ack) cap_mem_ack = 1'b0;
      else if (cap_mem_req) cap_mem_ack = 1'b1;
    end
  end

  // Main monitor: request stability and scoreboard compare on handshake.
  initial begin
    logic        prev_req;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;
    wr_t         e;
    prev_req = 1'b0; prev_addr = '0; prev_data = '0;
    forever begin
      @(negedge clk); #2;
      if (mem_req && prev_req) begin
        checks++;
        if (mem_addr !== prev_addr || mem_wdata !== prev_data) begin
          errors++;
          $display("FAIL req_stable addr=%h/%h data=%h/%h (actual/required)",
                   mem_addr, prev_addr, mem_wdata, prev_data);
        end
      end
      if (mem_req && mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h required none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("FAIL write actual addr=%h data=%h required addr=%h data=%h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
        prev_req = 1'b0;
      end else prev_req = mem_req;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  // Capacity-limited instance monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk); #2;
      if (cap_mem_req && cap_mem_ack) begin
        checks++;
        if (cap_exp_q.size() == 0) begin
          errors++;
          $display("FAIL cap_unexpected_write addr=%h data=%h required none",
                   cap_mem_addr, cap_mem_wdata);
        end else begin
          e = cap_exp_q.pop_front();
          if (cap_mem_addr !== e.addr || cap_mem_wdata !== e.data) begin
            errors++;
            $display("FAIL cap_write actual addr=%h data=%h required addr=%h data=%h",
                     cap_mem_addr, cap_mem_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input bit cap, input logic [7:0] b, input int hold);
    @(negedge clk);
    if (cap) begin cap_rx_data = b; cap_rx_valid = 1'b1; end
    else     begin rx_data = b;     rx_valid = 1'b1;     end
    repeat (hold) @(negedge clk);
    if (cap) cap_rx_valid = 1'b0; else rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clear(input bit cap);
    @(negedge clk);
    if (cap) cap_rx_clear = 1'b1; else rx_clear = 1'b1;
    repeat (2) @(negedge clk);
    if (cap) cap_rx_clear = 1'b0; else rx_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input bit cap, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((cap ? cap_done : done) === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout actual=0 required=1", name);
    end
  endtask

  task automatic do_restart(input string name);
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    chk({name, "_hold"},  32'(cpu_hold),   32'd1);
    chk({name, "_done"},  32'(done),       32'd0);
    chk({name, "_count"}, 32'(word_count), 32'd0);
    chk({name, "_addr"},  32'(mem_addr),   32'd0);
    chk({name, "_ovf"},   32'(overflow),   32'd0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_req"},   32'(mem_req),    32'd0);
    chk({name, "_addr"},  32'(mem_addr),   32'd0);
    chk({name, "_wdata"}, mem_wdata,       32'd0);
    chk({name, "_hold"},  32'(cpu_hold),   32'd1);
    chk({name, "_done"},  32'(done),       32'd0);
    chk({name, "_ovf"},   32'(overflow),   32'd0);
    chk({name, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v8[8];
    logic [7:0] v6[6];
    rst = 1'b1; restart = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_clear = 1'b0;
    cap_rx_data = 8'h00; cap_rx_valid = 1'b0; cap_rx_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Timeout with no image: stays idle, CPU held.
    pulse_clear(0);
    repeat (3) @(negedge clk);
    chk("idle_timeout_hold", 32'(cpu_hold), 32'd1);
    chk("idle_timeout_done", 32'(done),     32'd0);

    // Eight bytes, two full words.
    v8 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_q.push_back(wr_t'{8'h00, 32'h01020304});
    exp_q.push_back(wr_t'{8'h01, 32'h05060708});
    foreach (v8[i]) send_byte(0, v8[i], 1);
    pulse_clear(0);
    wait_done(0, "t1");
    chk("t1_count", 32'(word_count), 32'd2);
    chk("t1_done",  32'(done),       32'd1);
    chk("t1_hold",  32'(cpu_hold),   32'd0);
    do_restart("t1_restart");

    // Six bytes, padded tail word.
    v6 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    exp_q.push_back(wr_t'{8'h00, 32'hAABBCCDD});
    exp_q.push_back(wr_t'{8'h01, 32'hEEFF0000});
    foreach (v6[i]) send_byte(0, v6[i], 1);
    pulse_clear(0);
    wait_done(0, "t2");
    chk("t2_count", 32'(word_count), 32'd2);
    chk("t2_ovf",   32'(overflow),   32'd0);
    do_restart("t2_restart");

    // Valid held high for a long time per byte.
    exp_q.push_back(wr_t'{8'h00, 32'h11223344});
    send_byte(0, 8'h11, 500);
    send_byte(0, 8'h22, 500);
    send_byte(0, 8'h33, 500);
    send_byte(0, 8'h44, 500);
    pulse_clear(0);
    wait_done(0, "t3");
    chk("t3_count", 32'(word_count), 32'd1);
    do_restart("t3_restart");

    // Slow ack with one byte arriving mid-write.
    ack_delay = 20;
    exp_q.push_back(wr_t'{8'h00, 32'h10203040});
    exp_q.push_back(wr_t'{8'h01, 32'h50607080});
    send_byte(0, 8'h10, 1); send_byte(0, 8'h20, 1);
    send_byte(0, 8'h30, 1); send_byte(0, 8'h40, 1);
    send_byte(0, 8'h50, 1);
    repeat (30) @(negedge clk);
    send_byte(0, 8'h60, 1); send_byte(0, 8'h70, 1); send_byte(0, 8'h80, 1);
    pulse_clear(0);
    wait_done(0, "t4");
    chk("t4_count", 32'(word_count), 32'd2);
    chk("t4_ovf",   32'(overflow),   32'd0);
    do_restart("t4_restart");

    // Two bytes mid-write: first survives in skid, second overflows.
    exp_q.push_back(wr_t'{8'h00, 32'hA1A2A3A4});
    exp_q.push_back(wr_t'{8'h01, 32'hB1000000});
    send_byte(0, 8'hA1, 1); send_byte(0, 8'hA2, 1);
    send_byte(0, 8'hA3, 1); send_byte(0, 8'hA4, 1);
    send_byte(0, 8'hB1, 1); send_byte(0, 8'hB2, 1);
    repeat (40) @(negedge clk);
    pulse_clear(0);
    wait_done(0, "t5");
    chk("t5_ovf",   32'(overflow),   32'd1);
    chk("t5_count", 32'(word_count), 32'd2);
    do_restart("t5_restart");

    // Reset while a request is outstanding.
    send_byte(0, 8'hE1, 1); send_byte(0, 8'hE2, 1);
    send_byte(0, 8'hE3, 1); send_byte(0, 8'hE4, 1);
    for (int i = 0; i < 50; i++) begin
      if (mem_req) break;
      @(negedge clk);
    end
    chk("t6_req_before_reset", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("t6_midreset");
    ack_delay = 1;
    exp_q.push_back(wr_t'{8'h00, 32'h5A5B5C5D});
    send_byte(0, 8'h5A, 1); send_byte(0, 8'h5B, 1);
    send_byte(0, 8'h5C, 1); send_byte(0, 8'h5D, 1);
    pulse_clear(0);
    wait_done(0, "t6");
    chk("t6_count", 32'(word_count), 32'd1);

    // Capacity of two words, twelve bytes offered.
    cap_exp_q.push_back(wr_t'{8'h00, 32'hC0C1C2C3});
    cap_exp_q.push_back(wr_t'{8'h01, 32'hC4C5C6C7});
    for (int i = 0; i < 12; i++) send_byte(1, 8'hC0 + 8'(i), 1);
    pulse_clear(1);
    wait_done(1, "t7");
    chk("t7_count", 32'(cap_word_count), 32'd2);
    chk("t7_ovf",   32'(cap_overflow),   32'd1);
    chk("t7_hold",  32'(cap_cpu_hold),   32'd0);

    repeat (5) @(negedge clk);
    chk("exp_queue_empty",     32'(exp_q.size()),     32'd0);
    chk("cap_exp_queue_empty", 32'(cap_exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
